vec_dac_buf: RTL and testbench

Output stage for the vector display. It accepts signed Bresenham points through a valid/ready handshake and saturates each point to unsigned DAC range. Points are queued in a parametrised FIFO and presented to the X/Y DACs one per programmable dwell period. It sits between the line generator and the DAC pins, and replaces simple output gating with buffering, saturation, pacing and park/blanking control.

---
 rtl/vec_dac_buf_pkg.sv | 24 ++
 rtl/vec_dac_buf_if.sv | 12 +
 rtl/vec_dac_buf_fifo.sv | 69 ++++++
 rtl/vec_dac_buf.sv | 134 +++++++++++++
 tb/tb_vec_dac_buf.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vec_dac_buf_pkg.sv
// Shared definitions for the vector-display blocks: FSM state encoding and
// the signed-to-unsigned saturation helper.
package vec_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } vec_state_e;

    // Clamp a signed value into the unsigned range [0, 2^width-1].
    function automatic logic [31:0] sat_u(input logic signed [31:0] val,
                                          input int unsigned        width);
        logic signed [32:0] max_v;
        max_v = (33'sd1 <<< width) - 33'sd1;
        if (val < 0) begin
            return '0;
        end else if (33'(val) > max_v) begin
            return max_v[31:0];
        end else begin
            return val;
        end
    endfunction

endpackage

// File: rtl/vec_dac_buf_if.sv
// Point input handshake from the line generator: valid/ready plus signed X/Y.
interface vec_dac_buf_if #(
    parameter int unsigned BRES_WIDTH = 9
);
    logic                         in_valid;
    logic                         in_ready;
    logic signed [BRES_WIDTH-1:0] inx;
    logic signed [BRES_WIDTH-1:0] iny;

    modport master (output in_valid, inx, iny, input in_ready);
    modport slave  (input in_valid, inx, iny, output in_ready);
endinterface

// File: rtl/vec_dac_buf_fifo.sv
// Point FIFO with flush. Pointers carry an extra wrap bit so full and empty
// are told apart by the MSB. The read side sees the write pointer one cycle
// late, so an entry written into an empty FIFO becomes poppable a cycle later.
module vec_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]      wr_vis_q, wr_vis_d;
    logic             do_push, do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (rd_ptr_q == wr_vis_q);
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    // Next pointer values; flush returns everything to the empty state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        wr_vis_d = wr_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            wr_vis_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            wr_vis_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_vis_q <= wr_vis_d;
        end
    end

    // Storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/vec_dac_buf.sv
// Vector display output stage: saturates incoming points, queues them and
// presents one point per dwell period to the X/Y DACs, parking when disabled.
module vec_dac_buf
    import vec_pkg::*;
#(
    parameter int unsigned OUTWIDTH   = 8,
    parameter int unsigned BRES_WIDTH = 9,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DWELL_W    = 8,
    parameter int unsigned PARK_X     = 0,
    parameter int unsigned PARK_Y     = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    vec_dac_buf_if.slave              in_if,
    input  logic [DWELL_W-1:0]        dwell,
    output logic [OUTWIDTH-1:0]       outx,
    output logic [OUTWIDTH-1:0]       outy,
    output logic                      out_strobe,
    output logic                      beam_on,
    output logic [$clog2(DEPTH):0]    level
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic signed [BRES_WIDTH-1:0] inx_s, iny_s;
    logic [OUTWIDTH-1:0]          satx, saty;
    logic [2*OUTWIDTH-1:0]        fifo_rdata;
    logic                         fifo_full, fifo_empty;
    logic [LW-1:0]                fifo_level;
    logic                         push, pop;

    vec_state_e                   state_q, state_d;
    logic [DWELL_W-1:0]           cnt_q, cnt_d;
    logic [OUTWIDTH-1:0]          outx_q, outx_d;
    logic [OUTWIDTH-1:0]          outy_q, outy_d;
    logic                         strobe_q, strobe_d;
    logic                         beam_q, beam_d;

    assign inx_s = in_if.inx;
    assign iny_s = in_if.iny;
    assign satx  = OUTWIDTH'(sat_u(32'(inx_s), OUTWIDTH));
    assign saty  = OUTWIDTH'(sat_u(32'(iny_s), OUTWIDTH));

    // Ready is held low throughout reset regardless of enable.
    assign in_if.in_ready = rst_n && enable && !fifo_full;
    assign push           = in_if.in_valid && in_if.in_ready;

    vec_fifo #(
        .WIDTH (2 * OUTWIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (!enable),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({satx, saty}),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // Pacing FSM: pop, load outputs and dwell counter, or park when disabled.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        outx_d   = outx_q;
        outy_d   = outy_q;
        strobe_d = 1'b0;
        beam_d   = beam_q;
        pop      = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            outx_d  = OUTWIDTH'(PARK_X);
            outy_d  = OUTWIDTH'(PARK_Y);
            beam_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    beam_d = 1'b0;
                    pop    = !fifo_empty;
                end
                SHOW: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = IDLE;
                        beam_d  = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (pop) begin
                state_d  = SHOW;
                outx_d   = fifo_rdata[2*OUTWIDTH-1:OUTWIDTH];
                outy_d   = fifo_rdata[OUTWIDTH-1:0];
                strobe_d = 1'b1;
                beam_d   = 1'b1;
                cnt_d    = (dwell == '0) ? '0 : dwell - 1'b1;
            end
        end
    end

    // FSM state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            outx_q   <= OUTWIDTH'(PARK_X);
            outy_q   <= OUTWIDTH'(PARK_Y);
            strobe_q <= 1'b0;
            beam_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            outx_q   <= outx_d;
            outy_q   <= outy_d;
            strobe_q <= strobe_d;
            beam_q   <= beam_d;
        end
    end

    assign outx       = outx_q;
    assign outy       = outy_q;
    assign out_strobe = strobe_q;
    assign beam_on    = beam_q;
    assign level      = fifo_level;

endmodule

// File: tb/tb_vec_dac_buf.sv
// Directed bench for vec_dac_buf: reset, latency, dwell, saturation, full,
// disable/park and back-to-back presentation.
module tb_vec_dac_buf;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [7:0] dwell;
    logic [7:0] outx, outy;
    logic       out_strobe, beam_on;
    logic [4:0] level;

    int n_vec = 0;
    int n_err = 0;

    vec_dac_buf_if #(.BRES_WIDTH(10)) in_if ();

    vec_dac_buf #(
        .OUTWIDTH   (8),
        .BRES_WIDTH (10),
        .DEPTH      (16),
        .DWELL_W    (8),
        .PARK_X     (0),
        .PARK_Y     (0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .in_if      (in_if),
        .dwell      (dwell),
        .outx       (outx),
        .outy       (outy),
        .out_strobe (out_strobe),
        .beam_on    (beam_on),
        .level      (level)
    );

    always #5 clk = ~clk;

    int sat_in_x [5] = '{-5, 255, -512, 0, 128};
    int sat_in_y [5] = '{300, 256, 511, -1, 77};
    int sat_ex_x [5] = '{0, 255, 0, 0, 128};
    int sat_ex_y [5] = '{255, 255, 255, 0, 77};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one point for exactly one edge (the acceptance edge when ready).
    task automatic push_one(input int x, input int y);
        in_if.in_valid = 1'b1;
        in_if.inx      = 10'(x);
        in_if.iny      = 10'(y);
        step();
        in_if.in_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        rst_n          = 1'b0;
        enable         = 1'b1;
        dwell          = 8'd3;
        in_if.in_valid = 1'b0;
        in_if.inx      = '0;
        in_if.iny      = '0;

        // Reset state
        step(); step();
        check("rst_outx", outx, 0);
        check("rst_outy", outy, 0);
        check("rst_beam", beam_on, 0);
        check("rst_level", level, 0);
        check("rst_ready", in_if.in_ready, 0);
        rst_n = 1'b1;
        #1;
        check("rel_ready", in_if.in_ready, 1);
        step();

        // Single point, dwell 3: strobe two edges after acceptance
        push_one(10, 20);                      // edge k
        check("sp_k_level", level, 1);
        check("sp_k_strobe", out_strobe, 0);
        step();                                // k+1
        check("sp_k1_strobe", out_strobe, 0);
        check("sp_k1_beam", beam_on, 0);
        step();                                // k+2
        check("sp_k2_strobe", out_strobe, 1);
        check("sp_k2_beam", beam_on, 1);
        check("sp_k2_outx", outx, 10);
        check("sp_k2_outy", outy, 20);
        check("sp_k2_level", level, 0);
        step();                                // k+3
        check("sp_k3_strobe", out_strobe, 0);
        check("sp_k3_beam", beam_on, 1);
        step();                                // k+4
        check("sp_k4_beam", beam_on, 1);
        step();                                // k+5
        check("sp_k5_beam", beam_on, 0);
        check("sp_k5_outx", outx, 10);
        check("sp_k5_outy", outy, 20);

        // Saturation at write
        dwell = 8'd1;
        for (int i = 0; i < 5; i++) begin
            push_one(sat_in_x[i], sat_in_y[i]);
            step(); step();
            check("sat_strobe", out_strobe, 1);
            check("sat_outx", outx, sat_ex_x[i]);
            check("sat_outy", outy, sat_ex_y[i]);
            step(); step();
        end
        check("sat_idle_beam", beam_on, 0);

        // Full: first point moves to the display, the next 16 fill the FIFO
        dwell = 8'd200;
        acc = 0;
        in_if.in_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_if.inx = 10'(50 + i);
            in_if.iny = 10'(60 + i);
            if (in_if.in_ready) acc++;
            step();
        end
        check("full_acc", acc, 17);
        check("full_level", level, 16);
        check("full_ready", in_if.in_ready, 0);
        check("full_outx", outx, 50);
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            if (in_if.in_ready) acc++;
            step();
        end
        check("full_hold_acc", acc, 0);
        check("full_hold_level", level, 16);
        acc = 0;
        for (int i = 0; i < 250; i++) begin
            if (in_if.in_ready) acc++;
            step();
        end
        in_if.in_valid = 1'b0;
        check("full_refill_acc", acc, 1);
        check("full_refill_level", level, 16);
        check("full_next_outx", outx, 51);
        check("full_next_outy", outy, 61);

        // Disable: flush and park
        enable = 1'b0;
        step();
        check("dis0_level", level, 0);
        check("dis0_outx", outx, 0);
        check("dis0_beam", beam_on, 0);
        enable = 1'b1;
        in_if.in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_if.inx = 10'(100 + i);
            in_if.iny = 10'(110 + i);
            step();
        end
        in_if.in_valid = 1'b0;
        check("dis_pre_level", level, 5);
        check("dis_pre_beam", beam_on, 1);
        check("dis_pre_outx", outx, 100);
        enable = 1'b0;
        in_if.in_valid = 1'b1;
        in_if.inx = 10'd7;
        in_if.iny = 10'd7;
        #1;
        check("dis_ready", in_if.in_ready, 0);
        step();
        check("dis_outx", outx, 0);
        check("dis_outy", outy, 0);
        check("dis_level", level, 0);
        check("dis_beam", beam_on, 0);
        check("dis_strobe", out_strobe, 0);
        step();
        check("dis_noacc_level", level, 0);
        in_if.in_valid = 1'b0;
        enable = 1'b1;
        dwell = 8'd1;
        step();
        push_one(1, 1);                        // edge k
        check("reen_k_outx", outx, 0);
        step();
        check("reen_k1_strobe", out_strobe, 0);
        step();
        check("reen_k2_strobe", out_strobe, 1);
        check("reen_k2_outx", outx, 1);
        check("reen_k2_outy", outy, 1);
        step(); step();

        // Back-to-back with dwell 1
        in_if.in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_if.inx = 10'(10 * i);
            in_if.iny = 10'(10 * i + 1);
            step();                            // edges k, k+1, k+2
        end
        in_if.in_valid = 1'b0;
        check("b2b_k2_strobe", out_strobe, 1);
        check("b2b_k2_outx", outx, 10);
        step();
        check("b2b_k3_strobe", out_strobe, 1);
        check("b2b_k3_outx", outx, 20);
        step();
        check("b2b_k4_strobe", out_strobe, 1);
        check("b2b_k4_outx", outx, 30);
        check("b2b_k4_outy", outy, 31);
        check("b2b_k4_beam", beam_on, 1);
        step();
        check("b2b_k5_strobe", out_strobe, 0);
        check("b2b_k5_beam", beam_on, 0);
        check("b2b_k5_outx", outx, 30);
        check("b2b_k5_outy", outy, 31);

        // Dwell 0 behaves as 1
        dwell = 8'd0;
        push_one(40, 41);
        step(); step();
        check("dw0_beam_on", beam_on, 1);
        check("dw0_outx", outx, 40);
        step();
        check("dw0_beam_off", beam_on, 0);

        // Asynchronous reset mid-dwell
        dwell = 8'd50;
        in_if.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_if.inx = 10'(70 + i);
            in_if.iny = 10'(80 + i);
            step();
        end
        in_if.in_valid = 1'b0;
        step();
        check("mrst_pre_beam", beam_on, 1);
        check("mrst_pre_level", level, 2);
        #3;
        rst_n = 1'b0;
        #1;
        check("mrst_outx", outx, 0);
        check("mrst_outy", outy, 0);
        check("mrst_beam", beam_on, 0);
        check("mrst_level", level, 0);
        check("mrst_ready", in_if.in_ready, 0);
        step();
        rst_n = 1'b1;
        step();
        check("mrst_rel_ready", in_if.in_ready, 1);
        check("mrst_rel_level", level, 0);
        check("mrst_rel_beam", beam_on, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
